// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multi-cycle RV32I core. Every instruction runs
// through IF/ID/EX/MEM/WB. The FSM drives all datapath enables and mux
// selects. It stalls IF and MEM on a fixed-latency unified memory and stops
// the core on a halting ECALL.
module multicycle_control_fsm #(
    parameter int unsigned MEM_LATENCY = 1  // cycles per memory access, 1..15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       bcond,
    input  logic       halt_req,
    output logic       pc_write,
    output logic       pc_source,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] wb_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       alu_control,
    output logic       is_ecall,
    output logic       is_halted
);

    typedef enum logic [3:0] {
        S_IF,
        S_ID,
        S_EX,
        S_MEM,
        S_WB,
        S_JWB,
        S_ECALL,
        S_PC4,
        S_HALT
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IARITH = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_ECALL  = 7'b1110011;

    localparam logic [3:0] CNT_LAST = 4'(MEM_LATENCY - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    // Cleared by reset, set on the first edge after release. Keeps all
    // outputs low and the FSM parked in IF until that edge, so the first
    // IF cycle starts on a clean clock boundary.
    logic       run_q;
    logic       cnt_last;

    assign cnt_last = (cnt_q == CNT_LAST);

    // State, latency counter and run flag registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IF;
            cnt_q   <= '0;
            run_q   <= 1'b0;
        end else begin
            run_q <= 1'b1;
            if (run_q) begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end
    end

    // Next-state and counter logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IF: begin
                if (cnt_last) begin
                    cnt_d   = '0;
                    state_d = S_ID;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_ID: begin
                case (opcode)
                    OP_R, OP_IARITH, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR:
                        state_d = S_EX;
                    OP_JAL:   state_d = S_JWB;
                    OP_ECALL: state_d = S_ECALL;
                    default:  state_d = S_PC4;
                endcase
            end
            S_EX: begin
                case (opcode)
                    OP_R, OP_IARITH:   state_d = S_WB;
                    OP_LOAD, OP_STORE: state_d = S_MEM;
                    OP_JALR:           state_d = S_JWB;
                    OP_BRANCH:         state_d = bcond ? S_IF : S_PC4;
                    default:           state_d = S_PC4;
                endcase
            end
            S_MEM: begin
                if (cnt_last) begin
                    cnt_d   = '0;
                    state_d = (opcode == OP_LOAD) ? S_WB : S_IF;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_WB, S_JWB, S_PC4: state_d = S_IF;
            S_ECALL:            state_d = halt_req ? S_HALT : S_IF;
            S_HALT:             state_d = S_HALT;
            default:            state_d = S_IF;
        endcase
    end

    // Datapath control outputs, all low unless the state asserts them
    always_comb begin
        pc_write    = 1'b0;
        pc_source   = 1'b0;
        i_or_d      = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        wb_src      = 2'b00;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_control = 1'b0;
        is_ecall    = 1'b0;
        is_halted   = 1'b0;
        if (run_q) begin
            case (state_q)
                S_IF: begin
                    mem_read = 1'b1;
                    ir_write = cnt_last;
                end
                S_ID: begin
                    alu_src_b   = 2'b10;
                    alu_control = 1'b1;
                end
                S_EX: begin
                    alu_src_a = 1'b1;
                    case (opcode)
                        OP_R: ;
                        OP_IARITH: alu_src_b = 2'b10;
                        OP_LOAD, OP_STORE, OP_JALR: begin
                            alu_src_b   = 2'b10;
                            alu_control = 1'b1;
                        end
                        OP_BRANCH: begin
                            pc_write  = bcond;
                            pc_source = bcond;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    i_or_d = 1'b1;
                    if (opcode == OP_LOAD) begin
                        mem_read = 1'b1;
                    end else if (opcode == OP_STORE && cnt_last) begin
                        mem_write   = 1'b1;
                        alu_src_b   = 2'b01;
                        alu_control = 1'b1;
                        pc_write    = 1'b1;
                    end
                end
                S_WB: begin
                    reg_write   = 1'b1;
                    wb_src      = (opcode == OP_LOAD) ? 2'b01 : 2'b00;
                    alu_src_b   = 2'b01;
                    alu_control = 1'b1;
                    pc_write    = 1'b1;
                end
                S_JWB: begin
                    alu_src_b   = 2'b01;
                    alu_control = 1'b1;
                    reg_write   = 1'b1;
                    wb_src      = 2'b10;
                    pc_write    = 1'b1;
                    pc_source   = 1'b1;
                end
                S_ECALL: begin
                    is_ecall = 1'b1;
                    if (!halt_req) begin
                        alu_src_b   = 2'b01;
                        alu_control = 1'b1;
                        pc_write    = 1'b1;
                    end
                end
                S_PC4: begin
                    alu_src_b   = 2'b01;
                    alu_control = 1'b1;
                    pc_write    = 1'b1;
                end
                S_HALT: is_halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm. Three instances run side by
// side with MEM_LATENCY = 1, 2 and 3. Each instance's outputs are packed into
// one 16-bit word, which is compared every cycle against hand-written words.
module tb_multicycle_control_fsm;

    logic       clk;
    logic       reset;
    logic [6:0] opcode;
    logic       bcond;
    logic       halt_req;

    wire        pc_write_w    [3];
    wire        pc_source_w   [3];
    wire        i_or_d_w      [3];
    wire        mem_read_w    [3];
    wire        mem_write_w   [3];
    wire        ir_write_w    [3];
    wire        reg_write_w   [3];
    wire  [1:0] wb_src_w      [3];
    wire        alu_src_a_w   [3];
    wire  [1:0] alu_src_b_w   [3];
    wire        alu_control_w [3];
    wire        is_ecall_w    [3];
    wire        is_halted_w   [3];
    wire [15:0] obs           [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        multicycle_control_fsm #(.MEM_LATENCY(g + 1)) u_dut (
            .clk        (clk),
            .reset      (reset),
            .opcode     (opcode),
            .bcond      (bcond),
            .halt_req   (halt_req),
            .pc_write   (pc_write_w[g]),
            .pc_source  (pc_source_w[g]),
            .i_or_d     (i_or_d_w[g]),
            .mem_read   (mem_read_w[g]),
            .mem_write  (mem_write_w[g]),
            .ir_write   (ir_write_w[g]),
            .reg_write  (reg_write_w[g]),
            .wb_src     (wb_src_w[g]),
            .alu_src_a  (alu_src_a_w[g]),
            .alu_src_b  (alu_src_b_w[g]),
            .alu_control(alu_control_w[g]),
            .is_ecall   (is_ecall_w[g]),
            .is_halted  (is_halted_w[g])
        );
        // {pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write,
        //  reg_write, wb_src[1:0], alu_src_a, alu_src_b[1:0], alu_control,
        //  is_ecall, is_halted, 0}
        assign obs[g] = {pc_write_w[g], pc_source_w[g], i_or_d_w[g],
                         mem_read_w[g], mem_write_w[g], ir_write_w[g],
                         reg_write_w[g], wb_src_w[g], alu_src_a_w[g],
                         alu_src_b_w[g], alu_control_w[g], is_ecall_w[g],
                         is_halted_w[g], 1'b0};
    end

    // Expected output words (field order as packed above)
    localparam logic [15:0] E_ZERO     = 16'h0000;
    localparam logic [15:0] E_IF       = 16'h1000; // mem_read
    localparam logic [15:0] E_IF_LAST  = 16'h1400; // mem_read, ir_write
    localparam logic [15:0] E_ID       = 16'h0028; // b=10, add
    localparam logic [15:0] E_EX_R     = 16'h0040; // a=1, b=00, decode
    localparam logic [15:0] E_EX_I     = 16'h0060; // a=1, b=10, decode
    localparam logic [15:0] E_EX_ADDI  = 16'h0068; // a=1, b=10, add (ld/st/jalr)
    localparam logic [15:0] E_EX_BR_T  = 16'hC040; // a=1, pc_write, pc_source
    localparam logic [15:0] E_EX_BR_N  = 16'h0040; // a=1
    localparam logic [15:0] E_PC4      = 16'h8018; // pc_write, b=01, add
    localparam logic [15:0] E_WB_ALU   = 16'h8218; // PC4 + reg_write, wb=00
    localparam logic [15:0] E_WB_LD    = 16'h8298; // PC4 + reg_write, wb=01
    localparam logic [15:0] E_MEM_LD   = 16'h3000; // i_or_d, mem_read
    localparam logic [15:0] E_MEM_WAIT = 16'h2000; // i_or_d
    localparam logic [15:0] E_MEM_ST   = 16'hA818; // i_or_d, mem_write, PC4
    localparam logic [15:0] E_JWB      = 16'hC318; // pc_w, pc_src, reg_w, wb=10, b=01, add
    localparam logic [15:0] E_ECALL_N  = 16'h801C; // PC4 + is_ecall
    localparam logic [15:0] E_ECALL_H  = 16'h0004; // is_ecall
    localparam logic [15:0] E_HALT     = 16'h0002; // is_halted

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IARITH = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_ECALL  = 7'b1110011;
    localparam logic [6:0] OP_BAD    = 7'b0001111;

    int n_cmp  = 0;
    int n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input int l, input logic [15:0] exp, input string tag);
        logic [15:0] got;
        got = obs[l - 1];
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s (L=%0d): observed %h expected %h", tag, l, got, exp);
        end
    endtask

    task automatic step(input int l, input logic [15:0] exp, input string tag);
        @(negedge clk);
        check(l, exp, tag);
    endtask

    // Reset all instances, release mid-cycle, return just after the first
    // rising edge that follows release (start of cycle 0).
    task automatic start(input logic [6:0] opc, input logic bc, input logic hr);
        @(negedge clk);
        reset    = 1'b1;
        opcode   = opc;
        bcond    = bc;
        halt_req = hr;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        opcode   = OP_R;
        bcond    = 1'b0;
        halt_req = 1'b0;

        // Reset state: every output low on every instance
        @(negedge clk);
        check(1, E_ZERO, "reset_L1");
        check(2, E_ZERO, "reset_L2");
        check(3, E_ZERO, "reset_L3");

        // R-type, L=1; also outputs stay low in the gap between release and edge
        @(negedge clk);
        reset = 1'b0;
        #1 check(1, E_ZERO, "release_gap");
        @(posedge clk);
        step(1, E_IF_LAST, "r_c0_if");
        step(1, E_ID,      "r_c1_id");
        step(1, E_EX_R,    "r_c2_ex");
        step(1, E_WB_ALU,  "r_c3_wb");
        step(1, E_IF_LAST, "r_c4_if");

        // I-arith, L=1
        start(OP_IARITH, 1'b0, 1'b0);
        step(1, E_IF_LAST, "i_c0_if");
        step(1, E_ID,      "i_c1_id");
        step(1, E_EX_I,    "i_c2_ex");
        step(1, E_WB_ALU,  "i_c3_wb");

        // LOAD, L=3: 9 cycles
        start(OP_LOAD, 1'b0, 1'b0);
        step(3, E_IF,      "ld_c0_if");
        step(3, E_IF,      "ld_c1_if");
        step(3, E_IF_LAST, "ld_c2_if");
        step(3, E_ID,      "ld_c3_id");
        step(3, E_EX_ADDI, "ld_c4_ex");
        step(3, E_MEM_LD,  "ld_c5_mem");
        step(3, E_MEM_LD,  "ld_c6_mem");
        step(3, E_MEM_LD,  "ld_c7_mem");
        step(3, E_WB_LD,   "ld_c8_wb");
        step(3, E_IF,      "ld_c9_if");

        // STORE, L=2: 6 cycles, single mem_write with PC+4 on last MEM cycle
        start(OP_STORE, 1'b0, 1'b0);
        step(2, E_IF,       "st_c0_if");
        step(2, E_IF_LAST,  "st_c1_if");
        step(2, E_ID,       "st_c2_id");
        step(2, E_EX_ADDI,  "st_c3_ex");
        step(2, E_MEM_WAIT, "st_c4_mem");
        step(2, E_MEM_ST,   "st_c5_mem");
        step(2, E_IF,       "st_c6_if");

        // Branch taken, L=1: 3 cycles
        start(OP_BRANCH, 1'b1, 1'b0);
        step(1, E_IF_LAST, "bt_c0_if");
        step(1, E_ID,      "bt_c1_id");
        step(1, E_EX_BR_T, "bt_c2_ex");
        step(1, E_IF_LAST, "bt_c3_if");

        // Branch not taken, L=1: 4 cycles via PC4
        start(OP_BRANCH, 1'b0, 1'b0);
        step(1, E_IF_LAST, "bn_c0_if");
        step(1, E_ID,      "bn_c1_id");
        step(1, E_EX_BR_N, "bn_c2_ex");
        step(1, E_PC4,     "bn_c3_pc4");
        step(1, E_IF_LAST, "bn_c4_if");

        // JAL, L=1: JWB straight from ID
        start(OP_JAL, 1'b0, 1'b0);
        step(1, E_IF_LAST, "jal_c0_if");
        step(1, E_ID,      "jal_c1_id");
        step(1, E_JWB,     "jal_c2_jwb");
        step(1, E_IF_LAST, "jal_c3_if");

        // JALR, L=1: JWB via EX
        start(OP_JALR, 1'b0, 1'b0);
        step(1, E_IF_LAST, "jalr_c0_if");
        step(1, E_ID,      "jalr_c1_id");
        step(1, E_EX_ADDI, "jalr_c2_ex");
        step(1, E_JWB,     "jalr_c3_jwb");
        step(1, E_IF_LAST, "jalr_c4_if");

        // Unknown opcode, L=1: PC4 from ID
        start(OP_BAD, 1'b0, 1'b0);
        step(1, E_IF_LAST, "bad_c0_if");
        step(1, E_ID,      "bad_c1_id");
        step(1, E_PC4,     "bad_c2_pc4");
        step(1, E_IF_LAST, "bad_c3_if");

        // ECALL without halt, L=1
        start(OP_ECALL, 1'b0, 1'b0);
        step(1, E_IF_LAST, "ec_c0_if");
        step(1, E_ID,      "ec_c1_id");
        step(1, E_ECALL_N, "ec_c2_ecall");
        step(1, E_IF_LAST, "ec_c3_if");

        // ECALL with halt, L=1: HALT is absorbing
        start(OP_ECALL, 1'b0, 1'b1);
        step(1, E_IF_LAST, "eh_c0_if");
        step(1, E_ID,      "eh_c1_id");
        step(1, E_ECALL_H, "eh_c2_ecall");
        for (int i = 0; i < 22; i++) step(1, E_HALT, "eh_halt");

        // Reset during HALT: outputs drop at once, then a clean IF
        #2 reset = 1'b1;
        #1 check(1, E_ZERO, "rst_halt_async");
        halt_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        step(1, E_IF_LAST, "rst_halt_if");
        step(1, E_ID,      "rst_halt_id");

        // Reset during a MEM wait, L=3: no partial access, counter restarts
        start(OP_LOAD, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) @(negedge clk);
        step(3, E_MEM_LD, "rst_mem_c5");
        step(3, E_MEM_LD, "rst_mem_c6");
        #2 reset = 1'b1;
        #1 check(3, E_ZERO, "rst_mem_async");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        step(3, E_IF,      "rst_mem_if0");
        step(3, E_IF,      "rst_mem_if1");
        step(3, E_IF_LAST, "rst_mem_if2");
        step(3, E_ID,      "rst_mem_id");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
